pulse_transmitter: RTL and testbench
====================================

Name: pulse_transmitter

Overview:
- Transmit-side counterpart of the pulse receiver.
- On a START command it raises the T/R switch, waits a pre-guard time, then streams PULSE_LEN packed I/Q words from a waveform memory to the DAC at a programmable sample rate.
- It then holds T/R through a post-guard time and signals completion.
- It sits between the waveform RAM (synchronous, 1-cycle read latency) and the DAC interface, in the CLK domain.

Parameters:
- GUARD_PRE, 8, cycles TR_OUT is high before the first memory read (>=1)
- GUARD_POST, 8, cycles TR_OUT stays high after the last DAC sample (>=1)
- ADDR_W, 16, waveform memory address width; PULSE_LEN is the same width
- DAC_W, 16, width of each of I and Q; memory word width is 2*DAC_W

Ports:
- CLK  in  1  system clock; all logic on posedge
- RESET  in  1  asynchronous, active-high reset
- START  in  1  one-cycle transmit request
- ABORT  in  1  level; cut the pulse short
- PULSE_LEN  in  ADDR_W  number of samples to send
- DIV  in  8  sample strobe period minus 1 (DIV=0 gives one sample per clock)
- RD_EN  out  1  memory read strobe
- RD_ADDR  out  ADDR_W  memory read address
- RD_DATA  in  2*DAC_W  memory data, valid 1 cycle after RD_EN; {Q,I}
- DAC_I  out  DAC_W  I sample = RD_DATA[DAC_W-1:0]
- DAC_Q  out  DAC_W  Q sample = RD_DATA[2*DAC_W-1:DAC_W]
- DAC_VALID  out  1  one-cycle strobe per new sample
- TR_OUT  out  1  T/R switch, 1 = transmit
- BUSY  out  1  high in every state except IDLE
- TRANSMIT_OVER  out  1  one-cycle done pulse

Behaviour:
- Reset: all outputs are 0, state IDLE, all counters 0.
  - Reset asserted mid-operation drops TR_OUT, DAC_I, DAC_Q, DAC_VALID and RD_EN to 0 immediately (asynchronously).
  - No TRANSMIT_OVER is produced for the aborted pulse.
- All outputs are registered.
- States: IDLE -> PRE -> TX -> POST -> DONE -> IDLE.
- IDLE:
  - START=1 with PULSE_LEN!=0 latches PULSE_LEN and DIV and moves to PRE.
  - From the next cycle, TR_OUT=1 and BUSY=1.
  - START with PULSE_LEN==0 is ignored. START in any non-IDLE state is ignored.
- PRE: lasts exactly GUARD_PRE cycles, then TX.
- TX:
  - Read k (k=0..L-1) issues RD_EN=1 with RD_ADDR=k for one cycle.
  - Read 0 occurs in the first TX cycle; successive reads are spaced DIV+1 cycles apart.
  - Between reads RD_EN=0 and RD_ADDR holds its last value.
  - The DAC registers capture RD_DATA on the edge where it is valid, so DAC_I, DAC_Q and DAC_VALID appear 2 cycles after the corresponding RD_EN.
  - DAC_I and DAC_Q hold between strobes.
  - TX ends in the cycle carrying the last DAC_VALID.
  - TR_OUT high time = GUARD_PRE + (L-1)*(DIV+1) + 3 + GUARD_POST cycles.
- POST:
  - Entered the cycle after the last DAC_VALID.
  - DAC_I and DAC_Q are forced to 0 on entry; no reads occur.
  - Lasts GUARD_POST cycles.
- DONE: a single cycle with TR_OUT=0, BUSY=0 and TRANSMIT_OVER=1, then IDLE.
- ABORT=1 in PRE or TX:
  - Next cycle enters POST.
  - Any read already in flight is discarded and produces no DAC_VALID.
  - The full post-guard and TRANSMIT_OVER still occur.
- ABORT has no effect in IDLE, POST or DONE.
- Sample counter is ADDR_W wide; PULSE_LEN = 2^ADDR_W-1 must complete without wrap.
- Strobe divider reloads on each read, so DIV=255 yields a 256-cycle spacing.

Test Plan:
- GUARD_PRE=8, GUARD_POST=8, DIV=0, PULSE_LEN=4, START at cycle 0, memory word k = {16'h1000+k, 16'h2000+k}:
  - TR_OUT high for cycles 1-22.
  - RD_ADDR 0..3 in cycles 9-12.
  - DAC_VALID in cycles 11-14 with DAC_I=16'h2000..16'h2003 and DAC_Q=16'h1000..16'h1003.
  - TRANSMIT_OVER in cycle 23.
- DIV=3, PULSE_LEN=3 -> reads exactly 4 cycles apart; DAC_VALID count 3; TR_OUT high 8+2*4+3+8=27 cycles.
- START with PULSE_LEN=0 -> BUSY, TR_OUT and TRANSMIT_OVER stay 0. Second START during TX -> no restart; read count unchanged.
- ABORT raised during TX after the 2nd read (PULSE_LEN=10) -> no further RD_EN, at most 1 DAC_VALID after ABORT is discarded, DAC zeroed, TR_OUT high 8 more cycles, then TRANSMIT_OVER=1.
- RESET pulsed mid-TX -> TR_OUT, DAC_VALID and BUSY are 0 immediately with no TRANSMIT_OVER; a fresh START afterwards runs the normal sequence from address 0.
- Back-to-back: START held high through DONE -> exactly one new pulse begins from IDLE, with no overlap of TR_OUT between pulses (at least 1 low cycle).

Source files
------------

// File: rtl/pulse_transmitter.sv
// pulse_transmitter: transmit-side sequencer.
// Raises T/R, waits a pre-guard, streams PULSE_LEN {Q,I} words from a
// 1-cycle-latency waveform RAM to the DAC at a programmable strobe rate,
// holds T/R through a post-guard, then emits a one-cycle done pulse.
// Every output is a flop; next-state/next-output logic lives in one always_comb.
module pulse_transmitter #(
   parameter int GUARD_PRE  = 8,
   parameter int GUARD_POST = 8,
   parameter int ADDR_W     = 16,
   parameter int DAC_W      = 16
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 START,
   input  logic                 ABORT,
   input  logic [ADDR_W-1:0]    PULSE_LEN,
   input  logic [7:0]           DIV,
   output logic                 RD_EN,
   output logic [ADDR_W-1:0]    RD_ADDR,
   input  logic [2*DAC_W-1:0]   RD_DATA,
   output logic [DAC_W-1:0]     DAC_I,
   output logic [DAC_W-1:0]     DAC_Q,
   output logic                 DAC_VALID,
   output logic                 TR_OUT,
   output logic                 BUSY,
   output logic                 TRANSMIT_OVER
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PRE  = 3'd1,
      S_TX   = 3'd2,
      S_POST = 3'd3,
      S_DONE = 3'd4
   } state_t;

   // One guard counter serves both PRE and POST, so size it for the longer one.
   localparam int GMAX   = (GUARD_PRE > GUARD_POST) ? GUARD_PRE : GUARD_POST;
   localparam int GCNT_W = (GMAX > 1) ? $clog2(GMAX) : 1;
   localparam logic [GCNT_W-1:0] PRE_LAST  = GCNT_W'(GUARD_PRE - 1);
   localparam logic [GCNT_W-1:0] POST_LAST = GCNT_W'(GUARD_POST - 1);

   state_t               state_q,     state_d;
   logic [ADDR_W-1:0]    len_q,       len_d;        // latched PULSE_LEN
   logic [7:0]           div_q,       div_d;        // latched DIV
   logic [GCNT_W-1:0]    gcnt_q,      gcnt_d;       // guard-time counter
   logic [7:0]           div_cnt_q,   div_cnt_d;    // cycles until next read
   logic [ADDR_W-1:0]    rd_idx_q,    rd_idx_d;     // reads issued so far
   logic [ADDR_W-1:0]    out_cnt_q,   out_cnt_d;    // DAC samples emitted so far
   logic                 rd_vld_q,    rd_vld_d;     // RD_DATA valid this cycle
   logic                 rd_en_q,     rd_en_d;
   logic [ADDR_W-1:0]    rd_addr_q,   rd_addr_d;
   logic [DAC_W-1:0]     dac_i_q,     dac_i_d;
   logic [DAC_W-1:0]     dac_qd_q,    dac_qd_d;
   logic                 dac_valid_q, dac_valid_d;
   logic                 tr_q,        tr_d;
   logic                 busy_q,      busy_d;
   logic                 over_q,      over_d;
   logic                 go_post;

   // Next-state and next-output computation for the whole sequencer.
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      div_d       = div_q;
      gcnt_d      = gcnt_q;
      div_cnt_d   = div_cnt_q;
      rd_idx_d    = rd_idx_q;
      out_cnt_d   = out_cnt_q;
      rd_vld_d    = rd_en_q;       // RAM answers one cycle after the strobe
      rd_en_d     = 1'b0;
      rd_addr_d   = rd_addr_q;     // address holds between reads
      dac_i_d     = dac_i_q;       // samples hold between strobes
      dac_qd_d    = dac_qd_q;
      dac_valid_d = 1'b0;
      tr_d        = tr_q;
      busy_d      = busy_q;
      over_d      = 1'b0;
      go_post     = 1'b0;

      case (state_q)
         S_IDLE: begin
            tr_d   = 1'b0;
            busy_d = 1'b0;
            // A zero-length request would never produce a last sample; drop it.
            if (START && (PULSE_LEN != '0)) begin
               state_d = S_PRE;
               len_d   = PULSE_LEN;
               div_d   = DIV;
               gcnt_d  = '0;
               tr_d    = 1'b1;
               busy_d  = 1'b1;
            end
         end

         S_PRE: begin
            if (ABORT) begin
               go_post = 1'b1;
            end else if (gcnt_q == PRE_LAST) begin
               // Read 0 goes out in the first TX cycle.
               state_d   = S_TX;
               rd_en_d   = 1'b1;
               rd_addr_d = '0;
               rd_idx_d  = ADDR_W'(1);
               div_cnt_d = div_q;
               out_cnt_d = '0;
            end else begin
               gcnt_d = gcnt_q + 1'b1;
            end
         end

         S_TX: begin
            if (ABORT) begin
               // Anything still in the RAM pipe is dropped on the floor.
               go_post = 1'b1;
            end else begin
               // Read issue: divider reloads on every read.
               if (rd_idx_q != len_q) begin
                  if (div_cnt_q == 8'd0) begin
                     rd_en_d   = 1'b1;
                     rd_addr_d = rd_idx_q;
                     rd_idx_d  = rd_idx_q + ADDR_W'(1);
                     div_cnt_d = div_q;
                  end else begin
                     div_cnt_d = div_cnt_q - 8'd1;
                  end
               end
               // DAC capture on the edge where RAM data is valid.
               if (rd_vld_q) begin
                  dac_valid_d = 1'b1;
                  dac_i_d     = RD_DATA[DAC_W-1:0];
                  dac_qd_d    = RD_DATA[2*DAC_W-1:DAC_W];
                  out_cnt_d   = out_cnt_q + ADDR_W'(1);
               end
               // The cycle carrying the final strobe is the last TX cycle.
               if (dac_valid_q && (out_cnt_q == len_q)) begin
                  go_post = 1'b1;
               end
            end
         end

         S_POST: begin
            if (gcnt_q == POST_LAST) begin
               state_d = S_DONE;
               tr_d    = 1'b0;
               busy_d  = 1'b0;
               over_d  = 1'b1;
            end else begin
               gcnt_d = gcnt_q + 1'b1;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
            tr_d    = 1'b0;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = S_IDLE;
            tr_d    = 1'b0;
            busy_d  = 1'b0;
         end
      endcase

      // Shared POST entry: T/R stays up, DAC is parked at zero, no strobes.
      if (go_post) begin
         state_d     = S_POST;
         gcnt_d      = '0;
         rd_en_d     = 1'b0;
         rd_vld_d    = 1'b0;
         dac_valid_d = 1'b0;
         dac_i_d     = '0;
         dac_qd_d    = '0;
         tr_d        = 1'b1;
         busy_d      = 1'b1;
      end
   end

   // State and output registers; reset clears everything at once.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         div_q       <= '0;
         gcnt_q      <= '0;
         div_cnt_q   <= '0;
         rd_idx_q    <= '0;
         out_cnt_q   <= '0;
         rd_vld_q    <= 1'b0;
         rd_en_q     <= 1'b0;
         rd_addr_q   <= '0;
         dac_i_q     <= '0;
         dac_qd_q    <= '0;
         dac_valid_q <= 1'b0;
         tr_q        <= 1'b0;
         busy_q      <= 1'b0;
         over_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         div_q       <= div_d;
         gcnt_q      <= gcnt_d;
         div_cnt_q   <= div_cnt_d;
         rd_idx_q    <= rd_idx_d;
         out_cnt_q   <= out_cnt_d;
         rd_vld_q    <= rd_vld_d;
         rd_en_q     <= rd_en_d;
         rd_addr_q   <= rd_addr_d;
         dac_i_q     <= dac_i_d;
         dac_qd_q    <= dac_qd_d;
         dac_valid_q <= dac_valid_d;
         tr_q        <= tr_d;
         busy_q      <= busy_d;
         over_q      <= over_d;
      end
   end

   assign RD_EN         = rd_en_q;
   assign RD_ADDR       = rd_addr_q;
   assign DAC_I         = dac_i_q;
   assign DAC_Q         = dac_qd_q;
   assign DAC_VALID     = dac_valid_q;
   assign TR_OUT        = tr_q;
   assign BUSY          = busy_q;
   assign TRANSMIT_OVER = over_q;

endmodule

// File: tb/tb_pulse_transmitter.sv
// tb_pulse_transmitter: scenario tasks compare every cycle of a pulse against
// a timeline model built from the guard/strobe arithmetic of the transmitter.
module tb_pulse_transmitter;

   localparam int G1     = 8;
   localparam int G2     = 8;
   localparam int ADDR_W = 16;
   localparam int DAC_W  = 16;

   logic                CLK = 1'b0;
   logic                RESET;
   logic                START;
   logic                ABORT;
   logic [ADDR_W-1:0]   PULSE_LEN;
   logic [7:0]          DIV;
   logic                RD_EN;
   logic [ADDR_W-1:0]   RD_ADDR;
   logic [2*DAC_W-1:0]  RD_DATA;
   logic [DAC_W-1:0]    DAC_I;
   logic [DAC_W-1:0]    DAC_Q;
   logic                DAC_VALID;
   logic                TR_OUT;
   logic                BUSY;
   logic                TRANSMIT_OVER;

   int n_tests = 0;
   int n_fail  = 0;
   int prev_last = 0;            // last address the DUT has driven on RD_ADDR
   logic [15:0] qbase = 16'h1000;
   logic [15:0] ibase = 16'h2000;

   pulse_transmitter #(.GUARD_PRE(G1), .GUARD_POST(G2), .ADDR_W(ADDR_W), .DAC_W(DAC_W)) dut (
      .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT),
      .PULSE_LEN(PULSE_LEN), .DIV(DIV), .RD_EN(RD_EN), .RD_ADDR(RD_ADDR),
      .RD_DATA(RD_DATA), .DAC_I(DAC_I), .DAC_Q(DAC_Q), .DAC_VALID(DAC_VALID),
      .TR_OUT(TR_OUT), .BUSY(BUSY), .TRANSMIT_OVER(TRANSMIT_OVER)
   );

   always #5 CLK = ~CLK;

   // Waveform RAM: word k = {qbase+k, ibase+k}, one-cycle read latency.
   always @(posedge CLK) begin
      if (RD_EN) RD_DATA <= {qbase + RD_ADDR, ibase + RD_ADDR};
   end

   // Last TX cycle (relative to START cycle 0), honouring an abort at cycle a.
   function automatic int tx_last(input int l, input int d, input int a);
      int e;
      e = G1 + 1 + (l - 1) * (d + 1) + 2;
      return (a >= 1 && a < e) ? a : e;
   endfunction

   function automatic bit is_read(input int x, input int l, input int d, input int txl);
      int r0;
      r0 = G1 + 1;
      if (x < r0 || x > txl) return 1'b0;
      return ((x - r0) % (d + 1) == 0) && ((x - r0) / (d + 1) < l);
   endfunction

   // Expected outputs in cycle c of a pulse whose START is in cycle 0.
   function automatic void expect_at(input int c, input int l, input int d, input int a,
                                     input int prev, output logic [4:0] ctrl,
                                     output logic [15:0] addr, output logic [15:0] di,
                                     output logic [15:0] dq);
      int r0, step, txl, n, idx;
      logic tr, ov, re, dv;
      r0   = G1 + 1;
      step = d + 1;
      txl  = tx_last(l, d, a);
      tr   = (c >= 1) && (c <= txl + G2);
      ov   = (c == txl + G2 + 1);
      re   = is_read(c, l, d, txl);
      dv   = (c <= txl) && is_read(c - 2, l, d, txl);
      ctrl = {tr, tr, ov, re, dv};
      n = (c < txl) ? c : txl;
      if (n < r0) addr = 16'(prev);
      else begin
         idx  = (n - r0) / step;
         addr = 16'((idx > l - 1) ? l - 1 : idx);
      end
      if (c > txl || c < r0 + 2) begin
         di = 16'h0;
         dq = 16'h0;
      end else begin
         idx = (c - 2 - r0) / step;
         if (idx > l - 1) idx = l - 1;
         di = ibase + 16'(idx);
         dq = qbase + 16'(idx);
      end
   endfunction

   // Drive one START and check every cycle; r = cycle of a stray second START,
   // hold = keep START high through DONE so exactly one more pulse follows.
   task automatic run_pulse(input string nm, input int l, input int d, input int a,
                            input int r, input bit hold);
      int over1, ncyc, cc, aa, pv;
      logic [4:0] ec;
      logic [15:0] ea, ei, eq;
      over1 = tx_last(l, d, a) + G2 + 1;
      ncyc  = hold ? 2 * (over1 + 1) + 2 : over1 + 3;
      ea    = 16'(prev_last);
      @(posedge CLK); #1;
      START = 1'b1; PULSE_LEN = 16'(l); DIV = 8'(d); ABORT = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge CLK);
         if (hold && c > over1) begin cc = c - (over1 + 1); aa = -1; pv = l - 1; end
         else begin cc = c; aa = a; pv = prev_last; end
         expect_at(cc, l, d, aa, pv, ec, ea, ei, eq);
         n_tests++;
         if ({TR_OUT, BUSY, TRANSMIT_OVER, RD_EN, DAC_VALID} !== ec) begin
            n_fail++;
            $display("FAIL %s ctrl c=%0d got %b exp %b (tr,busy,over,rd_en,dv)", nm, c,
                     {TR_OUT, BUSY, TRANSMIT_OVER, RD_EN, DAC_VALID}, ec);
         end
         n_tests++;
         if (RD_ADDR !== ea) begin
            n_fail++;
            $display("FAIL %s rd_addr c=%0d got %h exp %h", nm, c, RD_ADDR, ea);
         end
         n_tests++;
         if ({DAC_Q, DAC_I} !== {eq, ei}) begin
            n_fail++;
            $display("FAIL %s dac c=%0d got %h exp %h", nm, c, {DAC_Q, DAC_I}, {eq, ei});
         end
         @(posedge CLK); #1;
         // Inputs wander after the latch point; the DUT must ignore them.
         START = (hold && (c + 1 <= over1 + 1)) || (c + 1 == r);
         ABORT = (c + 1 == a);
         if (!hold) begin PULSE_LEN = 16'(l + 3); DIV = 8'(d + 1); end
      end
      START = 1'b0; ABORT = 1'b0;
      prev_last = int'(ea);
   endtask

   task automatic test_reset;
      RESET = 1'b1; START = 1'b0; ABORT = 1'b0; PULSE_LEN = '0; DIV = '0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      n_tests++;
      if ({TR_OUT, BUSY, TRANSMIT_OVER, RD_EN, DAC_VALID, RD_ADDR, DAC_I, DAC_Q} !== '0) begin
         n_fail++;
         $display("FAIL reset_state got %b/%h/%h/%h exp all zero",
                  {TR_OUT, BUSY, TRANSMIT_OVER, RD_EN, DAC_VALID}, RD_ADDR, DAC_I, DAC_Q);
      end
      @(posedge CLK); #1;
      RESET = 1'b0;
      prev_last = 0;
   endtask

   task automatic test_zero_len;
      @(posedge CLK); #1;
      START = 1'b1; PULSE_LEN = '0; DIV = 8'd2;
      for (int c = 0; c < 12; c++) begin
         @(negedge CLK);
         n_tests++;
         if ({TR_OUT, BUSY, TRANSMIT_OVER, RD_EN} !== 4'b0) begin
            n_fail++;
            $display("FAIL zero_len c=%0d got %b exp 0000", c, {TR_OUT, BUSY, TRANSMIT_OVER, RD_EN});
         end
         @(posedge CLK); #1;
         START = 1'b0;
      end
   endtask

   task automatic test_reset_mid;
      @(posedge CLK); #1;
      qbase = 16'h5a00; ibase = 16'h0a50;
      START = 1'b1; PULSE_LEN = 16'd10; DIV = 8'd0;
      // Samples stream on cycles 11..20; cut the pulse in cycle 13.
      for (int c = 0; c < 13; c++) begin
         @(posedge CLK); #1;
         START = 1'b0;
      end
      @(negedge CLK);
      n_tests++;
      if ({TR_OUT, DAC_VALID} !== 2'b11) begin
         n_fail++;
         $display("FAIL rst_mid_pre got %b exp 11 (tr,dv)", {TR_OUT, DAC_VALID});
      end
      #2 RESET = 1'b1;
      #1;
      n_tests++;
      if ({TR_OUT, DAC_VALID, BUSY, RD_EN, DAC_I, DAC_Q} !== '0) begin
         n_fail++;
         $display("FAIL rst_mid_async got %b %h %h exp zero",
                  {TR_OUT, DAC_VALID, BUSY, RD_EN}, DAC_I, DAC_Q);
      end
      repeat (2) @(posedge CLK);
      #1 RESET = 1'b0;
      prev_last = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge CLK);
         n_tests++;
         if ({TRANSMIT_OVER, BUSY, TR_OUT} !== 3'b0) begin
            n_fail++;
            $display("FAIL rst_mid_quiet c=%0d got %b exp 000", c, {TRANSMIT_OVER, BUSY, TR_OUT});
         end
      end
      run_pulse("after_reset", 5, 1, -1, -1, 1'b0);
   endtask

   task automatic test_random;
      int l, d, a, e;
      for (int i = 0; i < 8; i++) begin
         l = int'($urandom_range(1, 12));
         d = int'($urandom_range(0, 4));
         e = G1 + 1 + (l - 1) * (d + 1) + 2;
         a = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, e)) : -1;
         qbase = 16'($urandom);
         ibase = 16'($urandom);
         run_pulse("random", l, d, a, -1, 1'b0);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      qbase = 16'h1000; ibase = 16'h2000;
      run_pulse("basic_L4_D0", 4, 0, -1, -1, 1'b0);
      run_pulse("div3_L3", 3, 3, -1, -1, 1'b0);
      run_pulse("single_L1", 1, 2, -1, -1, 1'b0);
      test_zero_len();
      run_pulse("restart_ignored", 6, 2, -1, 12, 1'b0);
      run_pulse("abort_tx", 10, 0, 11, -1, 1'b0);
      run_pulse("abort_tx_div", 10, 2, 14, -1, 1'b0);
      run_pulse("abort_pre", 4, 1, 4, -1, 1'b0);
      test_reset_mid();
      run_pulse("back_to_back", 3, 1, -1, -1, 1'b1);
      run_pulse("div255", 2, 255, -1, -1, 1'b0);
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
